// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dcache_pkg                                                  |
// | Brief  : Shared types and default geometry for the n-way data cache  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package dcache_pkg;

  // Default cache geometry
  localparam int unsigned c_def_num_sets = 16;
  localparam int unsigned c_def_num_ways = 4;
  localparam int unsigned c_def_tag_w    = 23;
  localparam int unsigned c_def_line_w   = 256;

  // Request opcodes; the reserved code behaves as a READ
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_lru.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dcache_lru                                                  |
// | Brief  : Age-based LRU update and replacement-way select for one set |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dcache_lru #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned WAY_W    = 2
) (
  input  logic [NUM_WAYS-1:0][WAY_W-1:0] age_i,
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic                           hit_i,
  input  logic [WAY_W-1:0]               hit_way_i,
  input  logic [WAY_W-1:0]               touch_way_i,
  output logic [NUM_WAYS-1:0][WAY_W-1:0] age_o,
  output logic [WAY_W-1:0]               victim_way_o
);

  logic             w_inv_found;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_old_way;

  // Touched way becomes age 0; every younger way ages by one, so the
  // ages stay a permutation of 0..NUM_WAYS-1.
  always_comb begin
    age_o = age_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == touch_way_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < age_i[touch_way_i]) begin
        age_o[w] = age_i[w] + WAY_W'(1);
      end
    end
  end

  // Replacement choice: hit way, else lowest invalid way, else oldest way.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_old_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (age_i[w] == WAY_W'(NUM_WAYS - 1)) begin
        w_old_way = WAY_W'(w);
      end
    end
    if (hit_i) begin
      victim_way_o = hit_way_i;
    end else if (w_inv_found) begin
      victim_way_o = w_inv_way;
    end else begin
      victim_way_o = w_old_way;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_sram_nway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dcache_sram_nway                                            |
// | Brief  : Set-associative write-back data cache array with LRU        |
// |          replacement, dirty-victim output and full flush scan        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS = c_def_num_sets,
  parameter int unsigned NUM_WAYS = c_def_num_ways,
  parameter int unsigned TAG_W    = c_def_tag_w,
  parameter int unsigned LINE_W   = c_def_line_w
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic [1:0]                  op_i,
  input  logic [$clog2(NUM_SETS)-1:0] index_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [LINE_W-1:0]           data_i,
  input  logic [LINE_W/8-1:0]         be_i,
  input  logic                        flush_i,
  output logic                        ready_o,
  output logic                        rsp_valid_o,
  output logic                        hit_o,
  output logic [LINE_W-1:0]           data_o,
  output logic                        victim_valid_o,
  output logic [$clog2(NUM_SETS)-1:0] victim_index_o,
  output logic [TAG_W-1:0]            victim_tag_o,
  output logic [LINE_W-1:0]           victim_data_o,
  output logic                        flush_done_o
);

  localparam int unsigned c_set_w  = $clog2(NUM_SETS);
  localparam int unsigned c_way_w  = $clog2(NUM_WAYS);
  localparam int unsigned c_be_w   = LINE_W / 8;
  localparam int unsigned c_scan_w = c_set_w + c_way_w;

  // Line storage
  logic [NUM_WAYS-1:0]              r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0]              r_dirty [NUM_SETS];
  logic [NUM_WAYS-1:0][c_way_w-1:0] r_age   [NUM_SETS];
  logic [TAG_W-1:0]                 r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]                r_line  [NUM_SETS][NUM_WAYS];

  // Control
  state_e              r_state;
  state_e              w_state_nxt;
  logic [c_scan_w-1:0] r_scan;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                w_flush_done_nxt;

  // Output registers
  logic                r_rsp_valid;
  logic                r_hit;
  logic [LINE_W-1:0]   r_data;
  logic                r_vic_valid;
  logic [c_set_w-1:0]  r_vic_index;
  logic [TAG_W-1:0]    r_vic_tag;
  logic [LINE_W-1:0]   r_vic_data;
  logic                r_flush_done;

  // Request-side lookup
  op_e                              w_op;
  logic                             w_accept;
  logic                             w_is_fill;
  logic                             w_is_write;
  logic                             w_is_read;
  logic [NUM_WAYS-1:0]              w_hit_vec;
  logic                             w_hit;
  logic [c_way_w-1:0]               w_hit_way;
  logic [c_way_w-1:0]               w_victim_way;
  logic [c_way_w-1:0]               w_touch_way;
  logic [NUM_WAYS-1:0][c_way_w-1:0] w_age_nxt;
  logic [LINE_W-1:0]                w_hit_line;
  logic [LINE_W-1:0]                w_merged;
  logic                             w_vic_evict;

  // Flush scan decode
  logic [c_set_w-1:0] w_scan_set;
  logic [c_way_w-1:0] w_scan_way;
  logic               w_scan_last;
  logic               w_scan_evict;

  assign w_op       = op_e'(op_i);
  assign w_accept   = req_i && r_ready && !flush_i;
  assign w_is_fill  = (w_op == OP_FILL);
  assign w_is_write = (w_op == OP_WRITE);
  assign w_is_read  = !w_is_fill && !w_is_write;

  assign w_scan_set   = r_scan[c_scan_w-1 -: c_set_w];
  assign w_scan_way   = r_scan[c_way_w-1:0];
  assign w_scan_last  = (r_scan == {c_scan_w{1'b1}});
  assign w_scan_evict = r_valid[w_scan_set][w_scan_way] && r_dirty[w_scan_set][w_scan_way];

  // Tag compare across the addressed set; at most one way can match.
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_hit_vec[w] = r_valid[index_i][w] && (r_tag[index_i][w] == tag_i);
      if (w_hit_vec[w]) begin
        w_hit_way = c_way_w'(w);
      end
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_touch_way = w_is_fill ? w_victim_way : w_hit_way;
  assign w_vic_evict = r_valid[index_i][w_victim_way] && r_dirty[index_i][w_victim_way] && !w_hit;

  // Byte-enable merge of write data into the hit line.
  always_comb begin
    w_hit_line = r_line[index_i][w_hit_way];
    w_merged   = w_hit_line;
    for (int b = 0; b < c_be_w; b++) begin
      if (be_i[b]) begin
        w_merged[b*8 +: 8] = data_i[b*8 +: 8];
      end
    end
  end

  // One shared LRU engine, fed with the ages of the addressed set.
  dcache_lru #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (c_way_w)
  ) u_lru (
    .age_i        (r_age[index_i]),
    .valid_i      (r_valid[index_i]),
    .hit_i        (w_hit),
    .hit_way_i    (w_hit_way),
    .touch_way_i  (w_touch_way),
    .age_o        (w_age_nxt),
    .victim_way_o (w_victim_way)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: flush entry from IDLE, exit after the last scan entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (flush_i && r_ready) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_scan_last)        w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead of their registers.
  always_comb begin
    w_ready_nxt      = (w_state_nxt == ST_IDLE);
    w_flush_done_nxt = (r_state == ST_FLUSH) && w_scan_last;
  end

  // Scan counter only advances in FLUSH and returns to 0 on the way out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scan <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_scan <= w_scan_last ? '0 : r_scan + c_scan_w'(1);
    end
  end

  // Valid, dirty and age state: reset, flush invalidation, request updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_age[s][w] <= c_way_w'(w);
        end
      end
    end else if (r_state == ST_FLUSH) begin
      r_valid[w_scan_set][w_scan_way] <= 1'b0;
      r_dirty[w_scan_set][w_scan_way] <= 1'b0;
    end else if (w_accept) begin
      if (w_is_fill) begin
        r_valid[index_i][w_victim_way] <= 1'b1;
        r_dirty[index_i][w_victim_way] <= 1'b0;
        r_age[index_i]                 <= w_age_nxt;
      end else if (w_hit) begin
        if (w_is_write) begin
          r_dirty[index_i][w_hit_way] <= 1'b1;
        end
        r_age[index_i] <= w_age_nxt;
      end
    end
  end

  // Tag and line arrays carry no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      if (w_is_fill) begin
        r_tag[index_i][w_victim_way]  <= tag_i;
        r_line[index_i][w_victim_way] <= data_i;
      end else if (w_is_write && w_hit) begin
        r_line[index_i][w_hit_way] <= w_merged;
      end
    end
  end

  // Registered response, victim and flush-status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready      <= 1'b1;
      r_flush_done <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_data       <= '0;
      r_vic_valid  <= 1'b0;
      r_vic_index  <= '0;
      r_vic_tag    <= '0;
      r_vic_data   <= '0;
    end else begin
      r_ready      <= w_ready_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_rsp_valid  <= w_accept;
      r_hit        <= w_accept && w_hit;
      r_data       <= (w_accept && w_is_read && w_hit) ? w_hit_line : '0;
      r_vic_valid  <= 1'b0;
      r_vic_index  <= '0;
      r_vic_tag    <= '0;
      r_vic_data   <= '0;
      if (r_state == ST_FLUSH) begin
        if (w_scan_evict) begin
          r_vic_valid <= 1'b1;
          r_vic_index <= w_scan_set;
          r_vic_tag   <= r_tag[w_scan_set][w_scan_way];
          r_vic_data  <= r_line[w_scan_set][w_scan_way];
        end
      end else if (w_accept && w_is_fill && w_vic_evict) begin
        r_vic_valid <= 1'b1;
        r_vic_index <= index_i;
        r_vic_tag   <= r_tag[index_i][w_victim_way];
        r_vic_data  <= r_line[index_i][w_victim_way];
      end
    end
  end

  assign ready_o        = r_ready;
  assign rsp_valid_o    = r_rsp_valid;
  assign hit_o          = r_hit;
  assign data_o         = r_data;
  assign victim_valid_o = r_vic_valid;
  assign victim_index_o = r_vic_index;
  assign victim_tag_o   = r_vic_tag;
  assign victim_data_o  = r_vic_data;
  assign flush_done_o   = r_flush_done;

endmodule
`default_nettype wire

// File: tb/tb_dcache_sram_nway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_dcache_sram_nway                                         |
// | Brief  : Scoreboard bench for dcache_sram_nway (default geometry)    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_dcache_sram_nway;
  import dcache_pkg::*;

  localparam int LW = 256;
  localparam int TW = 23;
  localparam int SW = 4;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [1:0]    op;
  logic [SW-1:0] index;
  logic [TW-1:0] tag;
  logic [LW-1:0] data;
  logic [BW-1:0] be;
  logic          flush;
  logic          ready;
  logic          rsp_valid;
  logic          hit;
  logic [LW-1:0] rdata;
  logic          vvalid;
  logic [SW-1:0] vindex;
  logic [TW-1:0] vtag;
  logic [LW-1:0] vdata;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          hit;
    logic [LW-1:0] data;
    logic          vv;
    logic [SW-1:0] vidx;
    logic [TW-1:0] vtag;
    logic [LW-1:0] vdata;
  } exp_t;

  exp_t sbq[$];
  exp_t vq[$];

  dcache_sram_nway dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .op_i           (op),
    .index_i        (index),
    .tag_i          (tag),
    .data_i         (data),
    .be_i           (be),
    .flush_i        (flush),
    .ready_o        (ready),
    .rsp_valid_o    (rsp_valid),
    .hit_o          (hit),
    .data_o         (rdata),
    .victim_valid_o (vvalid),
    .victim_index_o (vindex),
    .victim_tag_o   (vtag),
    .victim_data_o  (vdata),
    .flush_done_o   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] mk(input int t);
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'hC0DE_0000 + 32'(t * 16 + i);
    return r;
  endfunction

  function automatic exp_t ex(input logic h, input logic [LW-1:0] d, input logic v,
                              input logic [SW-1:0] vi, input logic [TW-1:0] vt,
                              input logic [LW-1:0] vd);
    exp_t e;
    e.hit = h; e.data = d; e.vv = v; e.vidx = vi; e.vtag = vt; e.vdata = vd;
    return e;
  endfunction

  // Response scoreboard: every rsp_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1, required no response");
      end else begin
        e = sbq.pop_front();
        if (hit !== e.hit) begin
          bad++; $display("FAIL rsp_hit: got %b required %b", hit, e.hit);
        end
        total++;
        if (rdata !== e.data) begin
          bad++; $display("FAIL rsp_data: got %h required %h", rdata, e.data);
        end
        total++;
        if (vvalid !== e.vv) begin
          bad++; $display("FAIL rsp_victim_valid: got %b required %b", vvalid, e.vv);
        end
        if (e.vv) begin
          total++;
          if (vindex !== e.vidx || vtag !== e.vtag || vdata !== e.vdata) begin
            bad++;
            $display("FAIL rsp_victim: got idx=%0d tag=%0d data=%h required idx=%0d tag=%0d data=%h",
                     vindex, vtag, vdata, e.vidx, e.vtag, e.vdata);
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [SW-1:0] i, input logic [TW-1:0] t,
                      input logic [LW-1:0] d, input logic [BW-1:0] b, input exp_t e);
    @(posedge clk); #1;
    req = 1'b1; op = o; index = i; tag = t; data = d; be = b;
    sbq.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd(input logic [SW-1:0] i, input logic [TW-1:0] t, input logic h, input logic [LW-1:0] d);
    send(OP_READ, i, t, '0, '0, ex(h, d, 1'b0, '0, '0, '0));
  endtask

  task automatic wr(input logic [SW-1:0] i, input logic [TW-1:0] t, input logic [LW-1:0] d,
                    input logic [BW-1:0] b, input logic h);
    send(OP_WRITE, i, t, d, b, ex(h, '0, 1'b0, '0, '0, '0));
  endtask

  task automatic fl(input logic [SW-1:0] i, input logic [TW-1:0] t, input logic h, input logic v,
                    input logic [TW-1:0] vt, input logic [LW-1:0] vd);
    send(OP_FILL, i, t, mk(int'(t)), '0, ex(h, '0, v, i, vt, vd));
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; flush = 1'b0; op = '0; index = '0; tag = '0; data = '0; be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1)     begin bad++; $display("FAIL reset_ready: got %b required 1", ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    total++; if (hit !== 1'b0)       begin bad++; $display("FAIL reset_hit: got %b required 0", hit); end
    total++; if (rdata !== '0)       begin bad++; $display("FAIL reset_data: got %h required 0", rdata); end
    total++; if (vvalid !== 1'b0)    begin bad++; $display("FAIL reset_victim_valid: got %b required 0", vvalid); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_flush_done: got %b required 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_reuse();
    for (int t = 1; t <= 4; t++) fl(4'd3, TW'(t), 1'b0, 1'b0, '0, '0);
    rd(4'd3, 23'd2, 1'b1, mk(2));
    fl(4'd3, 23'd5, 1'b0, 1'b0, '0, '0);       // oldest way held tag 1, clean
    rd(4'd3, 23'd1, 1'b0, '0);
    rd(4'd3, 23'd5, 1'b1, mk(5));
  endtask

  task automatic test_dirty_evict();
    logic [LW-1:0] wd;
    logic [LW-1:0] vd;
    wd = '1; wd[7:0] = 8'hAA;
    vd = mk(1); vd[7:0] = 8'hAA;
    for (int t = 1; t <= 4; t++) fl(4'd5, TW'(t), 1'b0, 1'b0, '0, '0);
    wr(4'd5, 23'd1, wd, 32'h1, 1'b1);
    for (int t = 2; t <= 4; t++) rd(4'd5, TW'(t), 1'b1, mk(t));
    fl(4'd5, 23'd6, 1'b0, 1'b1, 23'd1, vd);
    rd(4'd5, 23'd6, 1'b1, mk(6));
  endtask

  task automatic test_misses();
    rd(4'd3, 23'd9, 1'b0, '0);
    wr(4'd3, 23'd9, mk(99), '1, 1'b0);
    rd(4'd3, 23'd2, 1'b1, mk(2));
    fl(4'd3, 23'd10, 1'b0, 1'b0, '0, '0);      // LRU now points at tag 3
    rd(4'd3, 23'd3, 1'b0, '0);
    rd(4'd3, 23'd4, 1'b1, mk(4));
    rd(4'd3, 23'd10, 1'b1, mk(10));
    rd(4'd3, 23'd9, 1'b0, '0);
  endtask

  task automatic test_flush();
    int low;
    int nv;
    int nd;
    exp_t e;
    wr(4'd3, 23'd10, mk(110), '1, 1'b1);
    wr(4'd3, 23'd4, mk(104), '1, 1'b1);
    wr(4'd5, 23'd2, mk(102), '1, 1'b1);
    vq.push_back(ex(1'b0, '0, 1'b1, 4'd3, 23'd10, mk(110)));  // set 3 way 2
    vq.push_back(ex(1'b0, '0, 1'b1, 4'd3, 23'd4,  mk(104)));  // set 3 way 3
    vq.push_back(ex(1'b0, '0, 1'b1, 4'd5, 23'd2,  mk(102)));  // set 5 way 1
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    low = 0; nv = 0; nd = 0;
    for (int c = 0; c < 200 && nd == 0; c++) begin
      @(negedge clk);
      if (!ready) low++;
      if (done) nd++;
      if (vvalid) begin
        nv++;
        total++;
        if (vq.size() == 0) begin
          bad++; $display("FAIL flush_extra_victim: got idx=%0d tag=%0d required none", vindex, vtag);
        end else begin
          e = vq.pop_front();
          if (vindex !== e.vidx || vtag !== e.vtag || vdata !== e.vdata) begin
            bad++;
            $display("FAIL flush_victim: got idx=%0d tag=%0d data=%h required idx=%0d tag=%0d data=%h",
                     vindex, vtag, vdata, e.vidx, e.vtag, e.vdata);
          end
        end
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
      if (vvalid) nv++;
    end
    total++; if (nd !== 1)   begin bad++; $display("FAIL flush_done_count: got %0d required 1", nd); end
    total++; if (nv !== 3)   begin bad++; $display("FAIL flush_victim_count: got %0d required 3", nv); end
    total++; if (low !== 64) begin bad++; $display("FAIL flush_ready_low: got %0d required 64", low); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after: got %b required 1", ready); end
    for (int t = 2; t <= 10; t++) begin
      rd(4'd3, TW'(t), 1'b0, '0);
      rd(4'd5, TW'(t), 1'b0, '0);
    end
  endtask

  task automatic test_simultaneous();
    int nd;
    @(posedge clk); #1;
    req = 1'b1; op = OP_READ; index = 4'd3; tag = 23'd5; flush = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL simul_ready: got %b required 0", ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL simul_rsp_valid: got %b required 0", rsp_valid); end
    nd = 0;
    for (int c = 0; c < 100 && nd == 0; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++; if (nd !== 1) begin bad++; $display("FAIL simul_flush_done: got %0d required 1", nd); end
  endtask

  task automatic test_reset_in_flush();
    int nd;
    fl(4'd15, 23'd20, 1'b0, 1'b0, '0, '0);
    fl(4'd14, 23'd21, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstflush_ready: got %b required 1", ready); end
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL rstflush_done: got %0d pulses required 0", nd); end
    rd(4'd15, 23'd20, 1'b0, '0);
    rd(4'd14, 23'd21, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_fill_reuse();
    test_dirty_evict();
    test_misses();
    test_flush();
    test_simultaneous();
    test_reset_in_flush();
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++; $display("FAIL missing_rsp: got %0d outstanding required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
